seq_det_param: RTL and testbench

Parametrised, runtime-programmable serial pattern detector. It is the successor to the fixed 1010 Moore detector, generalised to a PAT_W-bit pattern with a runtime pattern length. It adds a selectable overlapping/non-overlapping mode, an input qualifier, and a saturating match counter. It sits on a serial bit stream and feeds a status/interrupt path with a registered one-cycle match pulse.

---
 rtl/seq_det_param.sv | 129 ++++++++++++
 tb/tb_seq_det_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with overlap control, input qualifier,
// saturating match counter and a registered one-cycle match pulse.
module seq_det_param #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0000_1010),
  parameter int               RST_LEN = 4,
  parameter int               CNT_W   = 8,
  parameter int               LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             clear,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             pattern,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] cur_pat,
  output logic [LEN_W-1:0] cur_len
);

  // MATCH owns bit 1 so the pulse output comes straight from a flop
  typedef enum logic [1:0] {
    S_FILL  = 2'b00,
    S_ARMED = 2'b01,
    S_MATCH = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_r, state_s;
  logic [PAT_W-1:0]   hist_r, hist_s, hist_sh_s, mask_s;
  logic [LEN_W-1:0]   fill_r, fill_s, fill_inc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [PAT_W-1:0]   cur_pat_r, cur_pat_s;
  logic [LEN_W-1:0]   cur_len_r, cur_len_s;
  logic               hit_s;

  // Shifted history, saturating fill and the length-masked pattern comparison
  always_comb begin
    hist_sh_s = (hist_r << 1'b1) | {{(PAT_W-1){1'b0}}, din};
    if (fill_r == FULL_LEN) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1'b1);
    end
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (LEN_W'(i) < cur_len_r);
    end
    hit_s = (fill_inc_s >= cur_len_r) &&
            (((hist_sh_s ^ cur_pat_r) & mask_s) == {PAT_W{1'b0}});
  end

  // Next-state logic: clear > pat_load > din_valid
  always_comb begin
    state_s   = state_r;
    hist_s    = hist_r;
    fill_s    = fill_r;
    cnt_s     = cnt_r;
    cur_pat_s = cur_pat_r;
    cur_len_s = cur_len_r;
    if (clear) begin
      state_s = S_FILL;
      hist_s  = {PAT_W{1'b0}};
      fill_s  = {LEN_W{1'b0}};
      cnt_s   = {CNT_W{1'b0}};
    end else if (pat_load) begin
      state_s   = S_FILL;
      fill_s    = {LEN_W{1'b0}};
      cur_pat_s = pat_in;
      if ((len_in == {LEN_W{1'b0}}) || (len_in > FULL_LEN)) begin
        cur_len_s = FULL_LEN;
      end else begin
        cur_len_s = len_in;
      end
    end else if (din_valid) begin
      hist_s = hist_sh_s;
      if (hit_s) begin
        state_s = S_MATCH;
        fill_s  = overlap ? fill_inc_s : {LEN_W{1'b0}};
        if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end else begin
          cnt_s = cnt_r;
        end
      end else begin
        fill_s  = fill_inc_s;
        state_s = (fill_inc_s >= cur_len_r) ? S_ARMED : S_FILL;
      end
    end else begin
      case (state_r)
        S_MATCH: state_s = (fill_r >= cur_len_r) ? S_ARMED : S_FILL;
        S_FILL:  state_s = S_FILL;
        S_ARMED: state_s = S_ARMED;
        default: state_s = S_FILL;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_FILL;
      hist_r    <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      cur_pat_r <= RST_PAT;
      cur_len_r <= LEN_W'(RST_LEN);
    end else begin
      state_r   <= state_s;
      hist_r    <= hist_s;
      fill_r    <= fill_s;
      cnt_r     <= cnt_s;
      cur_pat_r <= cur_pat_s;
      cur_len_r <= cur_len_s;
    end
  end

  assign pattern   = state_r[1];
  assign match_cnt = cnt_r;
  assign cur_pat   = cur_pat_r;
  assign cur_len   = cur_len_r;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a queue-based model of the valid bits since the
// last restart is checked against the DUT every cycle, plus literal expectations.
module tb_seq_det_param;
  localparam int PAT_W = 8;
  localparam int CNT_W = 3;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             overlap = 1'b0;
  logic             clear = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = 8'h00;
  logic [LEN_W-1:0] len_in = 4'd0;
  logic             pattern;
  logic [CNT_W-1:0] match_cnt;
  logic [PAT_W-1:0] cur_pat;
  logic [LEN_W-1:0] cur_len;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int run = 0;
  int max_run = 0;
  bit chk_en = 1'b0;

  bit         q[$];
  int         m_len;
  logic [7:0] m_pat;
  int         m_cnt;
  bit         m_pulse;

  seq_det_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .clear(clear), .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in),
    .pattern(pattern), .match_cnt(match_cnt), .cur_pat(cur_pat), .cur_len(cur_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_len = 4;
    m_pat = 8'h0A;
    m_cnt = 0;
    m_pulse = 1'b0;
  endtask

  // last received bit lines up with pattern bit 0, earlier bits with higher bits
  function automatic bit m_hit();
    if (q.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (q[q.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (clear) begin
      q.delete();
      m_cnt = 0;
      m_pulse = 1'b0;
    end else if (pat_load) begin
      m_pat = pat_in;
      m_len = (len_in == 4'd0 || len_in > 4'd8) ? 8 : int'(len_in);
      q.delete();
      m_pulse = 1'b0;
    end else if (din_valid) begin
      q.push_back(din);
      if (q.size() > PAT_W) void'(q.pop_front());
      m_pulse = m_hit();
      if (m_pulse) begin
        if (m_cnt < 7) m_cnt++;
        if (!overlap) q.delete();
      end
    end else begin
      m_pulse = 1'b0;
    end
  endtask

  task automatic cyc(input bit d, input bit v);
    din = d;
    din_valid = v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [31:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(bits[i], 1'b1);
      if (gaps) cyc(1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1'b1, 1'b1);
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l);
    pat_in = p;
    len_in = l;
    pat_load = 1'b1;
    cyc(1'b1, 1'b1);
    pat_load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pattern", {31'd0, pattern}, {31'd0, m_pulse});
      chk("match_cnt", {29'd0, match_cnt}, m_cnt);
      chk("cur_pat", {24'd0, cur_pat}, {24'd0, m_pat});
      chk("cur_len", {28'd0, cur_len}, m_len);
      if (pattern === 1'b1) begin
        pulses++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pattern", {31'd0, pattern}, 32'd0);
    chk("rst_cnt", {29'd0, match_cnt}, 32'd0);
    chk("rst_pat", {24'd0, cur_pat}, 32'h0A);
    chk("rst_len", {28'd0, cur_len}, 32'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rel_pattern", {31'd0, pattern}, 32'd0);
    cyc(1'b0, 1'b0);

    overlap = 1'b1;
    pulses = 0;
    send(32'b1010101010, 10, 1'b0);
    chk("ovl_pulses", pulses, 32'd4);
    chk("ovl_cnt", {29'd0, match_cnt}, 32'd4);

    do_clear();
    chk("clr_cnt", {29'd0, match_cnt}, 32'd0);
    overlap = 1'b0;
    pulses = 0;
    send(32'b1010101010, 10, 1'b0);
    chk("novl_pulses", pulses, 32'd2);
    chk("novl_cnt", {29'd0, match_cnt}, 32'd2);

    do_clear();
    overlap = 1'b1;
    pulses = 0;
    max_run = 0;
    send(32'b1010101010, 10, 1'b1);
    chk("gap_pulses", pulses, 32'd4);
    chk("gap_width", max_run, 32'd1);
    chk("gap_cnt", {29'd0, match_cnt}, 32'd4);

    do_load(8'hB1, 4'd8);
    chk("load_pat", {24'd0, cur_pat}, 32'hB1);
    chk("load_len", {28'd0, cur_len}, 32'd8);
    chk("load_cnt_kept", {29'd0, match_cnt}, 32'd4);
    pulses = 0;
    send(32'b10110001, 8, 1'b0);
    chk("b1_pulses", pulses, 32'd1);
    chk("b1_cnt", {29'd0, match_cnt}, 32'd5);

    do_load(8'hB1, 4'd0);
    chk("len0", {28'd0, cur_len}, 32'd8);
    do_load(8'h0A, 4'd9);
    chk("len9", {28'd0, cur_len}, 32'd8);

    do_load(8'h01, 4'd1);
    do_clear();
    pulses = 0;
    repeat (10) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("sat_cnt", {29'd0, match_cnt}, 32'd7);
    chk("sat_pulses", pulses, 32'd10);

    do_clear();
    chk("clr2_cnt", {29'd0, match_cnt}, 32'd0);
    chk("clr2_pattern", {31'd0, pattern}, 32'd0);
    cyc(1'b1, 1'b1);
    chk("clr2_next", {31'd0, pattern}, 32'd1);
    chk("clr2_cnt1", {29'd0, match_cnt}, 32'd1);

    do_load(8'h05, 4'd3);
    cyc(1'b0, 1'b0);
    overlap = 1'b1;
    din = 1'b1; din_valid = 1'b1; @(posedge clk); model_edge(); #1;
    din = 1'b0; @(posedge clk); model_edge(); #1;
    din = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_pattern", {31'd0, pattern}, 32'd0);
    chk("arst_cnt", {29'd0, match_cnt}, 32'd0);
    chk("arst_pat", {24'd0, cur_pat}, 32'h0A);
    chk("arst_len", {28'd0, cur_len}, 32'd4);
    #1 rst = 1'b1;
    pulses = 0;
    send(32'b010, 3, 1'b0);
    chk("arst_nopulse", pulses, 32'd0);
    send(32'b10, 2, 1'b0);
    chk("arst_pulse", pulses, 32'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
